// File: rtl/tlb_unit.sv
// Joint TLB: CP0 TLBWI/TLBWR/TLBR/TLBP service plus one data-side translation port.
// All results are registered and appear one cycle after the request.
module tlb_unit #(
   parameter int unsigned IDXBITS = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tlbwi,
   input  logic        tlbwr,
   input  logic        tlbr_req,
   input  logic        tlbp_req,
   input  logic [31:0] cp0_index,
   input  logic [31:0] cp0_random,
   input  logic [31:0] cp0_entryhi,
   input  logic [31:0] cp0_entrylo0,
   input  logic [31:0] cp0_entrylo1,
   input  logic [11:0] cp0_mask,
   output logic        tlbr,
   output logic [31:0] tlbr_lo0,
   output logic [31:0] tlbr_lo1,
   output logic [31:0] tlbr_hi,
   output logic [11:0] tlbr_mask,
   output logic        tlbp,
   output logic [31:0] tlbp_index,
   input  logic        lk_req,
   input  logic [31:0] lk_vaddr,
   input  logic        lk_store,
   output logic        lk_valid,
   output logic [31:0] lk_paddr,
   output logic [2:0]  lk_cattr,
   output logic        lk_miss,
   output logic        lk_invalid,
   output logic        lk_modified
);

   localparam int unsigned ENTRIES = 1 << IDXBITS;
   localparam int unsigned VPNW    = 19;
   localparam int unsigned HALFW   = 25;
   localparam int unsigned MASKW   = 12;
   localparam int unsigned ASIDW   = 8;
   localparam int unsigned KW      = 4;

   // Entry storage; only present_q is reset, contents survive reset.
   logic [ENTRIES-1:0] present_q;
   logic [ENTRIES-1:0] g_q;
   logic [VPNW-1:0]    vpn2_q [ENTRIES];
   logic [ASIDW-1:0]   asid_q [ENTRIES];
   logic [MASKW-1:0]   mask_q [ENTRIES];
   logic [HALFW-1:0]   lo0_q  [ENTRIES];
   logic [HALFW-1:0]   lo1_q  [ENTRIES];

   logic               we_c;
   logic [IDXBITS-1:0] widx_c;
   logic [IDXBITS-1:0] ridx_c;
   logic [ENTRIES-1:0] lk_match_c;
   logic [ENTRIES-1:0] pb_match_c;
   logic               lk_hit_c;
   logic               pb_hit_c;
   logic [IDXBITS-1:0] lk_idx_c;
   logic [IDXBITS-1:0] pb_idx_c;
   logic [MASKW-1:0]   sel_mask_c;
   logic [KW-1:0]      k_c;
   logic               odd_c;
   logic [HALFW-1:0]   half_c;
   logic [31:0]        lowmask_c;
   logic [31:0]        paddr_c;
   logic               unused_bits_c;

   assign we_c   = tlbwi | tlbwr;
   assign widx_c = tlbwi ? cp0_index[IDXBITS-1:0] : cp0_random[IDXBITS-1:0];
   assign ridx_c = cp0_index[IDXBITS-1:0];

   assign unused_bits_c = ^{cp0_index[31:IDXBITS], cp0_random[31:IDXBITS], cp0_entryhi[12:8],
                            cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

   // Per-entry match for the translation port and the probe.
   always_comb begin
      lk_match_c = '0;
      pb_match_c = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         lk_match_c[i] = present_q[i]
                      && ((lk_vaddr[31:13] & ~{7'b0, mask_q[i]}) == vpn2_q[i])
                      && (g_q[i] || (asid_q[i] == cp0_entryhi[7:0]));
         pb_match_c[i] = present_q[i]
                      && ((cp0_entryhi[31:13] & ~{7'b0, mask_q[i]}) == vpn2_q[i])
                      && (g_q[i] || (asid_q[i] == cp0_entryhi[7:0]));
      end
   end

   // Lowest matching index wins.
   always_comb begin
      lk_hit_c = |lk_match_c;
      pb_hit_c = |pb_match_c;
      lk_idx_c = '0;
      pb_idx_c = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (lk_match_c[i]) lk_idx_c = IDXBITS'(i);
         if (pb_match_c[i]) pb_idx_c = IDXBITS'(i);
      end
   end

   // Page size from the (contiguous) mask selects the even/odd half and the offset width.
   always_comb begin
      sel_mask_c = mask_q[lk_idx_c];
      k_c        = '0;
      for (int j = 0; j < MASKW; j++) k_c = k_c + KW'(sel_mask_c[j]);
      odd_c      = lk_vaddr[5'd12 + 5'(k_c)];
      half_c     = odd_c ? lo1_q[lk_idx_c] : lo0_q[lk_idx_c];
      lowmask_c  = {8'b0, sel_mask_c, 12'hfff};
      paddr_c    = ({half_c[24:5], 12'b0} & ~lowmask_c) | (lk_vaddr & lowmask_c);
   end

   always_ff @(posedge clk) begin
      if (we_c) begin
         vpn2_q[widx_c] <= cp0_entryhi[31:13] & ~{7'b0, cp0_mask};
         asid_q[widx_c] <= cp0_entryhi[7:0];
         mask_q[widx_c] <= cp0_mask;
         lo0_q[widx_c]  <= cp0_entrylo0[25:1];
         lo1_q[widx_c]  <= cp0_entrylo1[25:1];
         g_q[widx_c]    <= cp0_entrylo0[0] & cp0_entrylo1[0];
      end
   end

   // Present bits and all registered outputs; reads see pre-write contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         present_q   <= '0;
         tlbr        <= 1'b0;
         tlbr_lo0    <= '0;
         tlbr_lo1    <= '0;
         tlbr_hi     <= '0;
         tlbr_mask   <= '0;
         tlbp        <= 1'b0;
         tlbp_index  <= '0;
         lk_valid    <= 1'b0;
         lk_paddr    <= '0;
         lk_cattr    <= '0;
         lk_miss     <= 1'b0;
         lk_invalid  <= 1'b0;
         lk_modified <= 1'b0;
      end else begin
         if (we_c) present_q[widx_c] <= 1'b1;

         tlbr <= tlbr_req;
         if (tlbr_req && present_q[ridx_c]) begin
            tlbr_hi   <= {vpn2_q[ridx_c], 5'b0, asid_q[ridx_c]};
            tlbr_lo0  <= {6'b0, lo0_q[ridx_c], g_q[ridx_c]};
            tlbr_lo1  <= {6'b0, lo1_q[ridx_c], g_q[ridx_c]};
            tlbr_mask <= mask_q[ridx_c];
         end else begin
            tlbr_hi   <= '0;
            tlbr_lo0  <= '0;
            tlbr_lo1  <= '0;
            tlbr_mask <= '0;
         end

         tlbp <= tlbp_req;
         if (!tlbp_req)     tlbp_index <= '0;
         else if (pb_hit_c) tlbp_index <= 32'(pb_idx_c);
         else               tlbp_index <= 32'h8000_0000;

         lk_valid    <= lk_req;
         lk_miss     <= lk_req & ~lk_hit_c;
         lk_invalid  <= lk_req & lk_hit_c & ~half_c[0];
         lk_modified <= lk_req & lk_hit_c & lk_store & half_c[0] & ~half_c[1];
         lk_paddr    <= (lk_req && lk_hit_c) ? paddr_c : '0;
         lk_cattr    <= (lk_req && lk_hit_c) ? half_c[4:2] : '0;
      end
   end

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: expected results are queued at stimulus time
// and popped when the corresponding strobe appears.
module tb_tlb_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        tlbwi, tlbwr, tlbr_req, tlbp_req;
   logic [31:0] cp0_index, cp0_random, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
   logic [11:0] cp0_mask;
   logic        tlbr, tlbp;
   logic [31:0] tlbr_lo0, tlbr_lo1, tlbr_hi, tlbp_index;
   logic [11:0] tlbr_mask;
   logic        lk_req, lk_store;
   logic [31:0] lk_vaddr;
   logic        lk_valid, lk_miss, lk_invalid, lk_modified;
   logic [31:0] lk_paddr;
   logic [2:0]  lk_cattr;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        valid;
      logic        miss;
      logic        invalid;
      logic        modified;
      logic [31:0] paddr;
      logic [2:0]  cattr;
   } lk_t;

   typedef struct packed {
      logic        stb;
      logic [31:0] hi;
      logic [31:0] lo0;
      logic [31:0] lo1;
      logic [11:0] mask;
   } rd_t;

   lk_t         lk_q [$];
   rd_t         rd_q [$];
   logic [32:0] pb_q [$];

   always #5 clk = ~clk;

   tlb_unit dut (
      .clk          (clk),
      .reset        (reset),
      .tlbwi        (tlbwi),
      .tlbwr        (tlbwr),
      .tlbr_req     (tlbr_req),
      .tlbp_req     (tlbp_req),
      .cp0_index    (cp0_index),
      .cp0_random   (cp0_random),
      .cp0_entryhi  (cp0_entryhi),
      .cp0_entrylo0 (cp0_entrylo0),
      .cp0_entrylo1 (cp0_entrylo1),
      .cp0_mask     (cp0_mask),
      .tlbr         (tlbr),
      .tlbr_lo0     (tlbr_lo0),
      .tlbr_lo1     (tlbr_lo1),
      .tlbr_hi      (tlbr_hi),
      .tlbr_mask    (tlbr_mask),
      .tlbp         (tlbp),
      .tlbp_index   (tlbp_index),
      .lk_req       (lk_req),
      .lk_vaddr     (lk_vaddr),
      .lk_store     (lk_store),
      .lk_valid     (lk_valid),
      .lk_paddr     (lk_paddr),
      .lk_cattr     (lk_cattr),
      .lk_miss      (lk_miss),
      .lk_invalid   (lk_invalid),
      .lk_modified  (lk_modified)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // paddr/cattr are don't-care on a miss, so they are zeroed before comparing.
   function automatic lk_t cap_lk();
      lk_t r;
      r = '{lk_valid, lk_miss, lk_invalid, lk_modified, lk_paddr, lk_cattr};
      if (lk_miss) begin
         r.paddr = '0;
         r.cattr = '0;
      end
      return r;
   endfunction

   task automatic write(input bit use_wr, input logic [31:0] idx, input logic [31:0] hi,
                        input logic [31:0] lo0, input logic [31:0] lo1, input logic [11:0] m);
      if (use_wr) begin
         cp0_random = idx;
         tlbwr      = 1'b1;
      end else begin
         cp0_index  = idx;
         tlbwi      = 1'b1;
      end
      cp0_entryhi  = hi;
      cp0_entrylo0 = lo0;
      cp0_entrylo1 = lo1;
      cp0_mask     = m;
      tick();
      tlbwi = 1'b0;
      tlbwr = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] a, input logic st, output lk_t o);
      lk_req   = 1'b1;
      lk_vaddr = a;
      lk_store = st;
      tick();
      lk_req = 1'b0;
      for (int n = 0; n < 4 && lk_valid !== 1'b1; n++) tick();
      o = cap_lk();
   endtask

   task automatic read(input logic [31:0] idx, output rd_t o);
      cp0_index = idx;
      tlbr_req  = 1'b1;
      tick();
      tlbr_req = 1'b0;
      for (int n = 0; n < 4 && tlbr !== 1'b1; n++) tick();
      o = '{tlbr, tlbr_hi, tlbr_lo0, tlbr_lo1, tlbr_mask};
   endtask

   task automatic probe(input logic [31:0] hi, output logic [32:0] o);
      cp0_entryhi = hi;
      tlbp_req    = 1'b1;
      tick();
      tlbp_req = 1'b0;
      for (int n = 0; n < 4 && tlbp !== 1'b1; n++) tick();
      o = {tlbp, tlbp_index};
   endtask

   task automatic test_reset();
      lk_t         o, e;
      logic [32:0] po, pe;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({tlbr, tlbp, lk_valid, lk_miss, tlbp_index, tlbr_hi, lk_paddr} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got tlbr=%b tlbp=%b lk_valid=%b idx=%h hi=%h pa=%h exp all 0",
                  tlbr, tlbp, lk_valid, tlbp_index, tlbr_hi, lk_paddr);
      end
      lk_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0});
      lookup(32'h0000_0000, 1'b0, o);
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL reset_lookup_miss got=%h exp=%h", o, e); end
      pb_q.push_back({1'b1, 32'h8000_0000});
      probe(32'h0000_0000, po);
      pe = pb_q.pop_front();
      checks++;
      if (po !== pe) begin failures++; $display("FAIL reset_probe_miss got=%h exp=%h", po, pe); end
   endtask

   task automatic test_translate();
      lk_t o, e;
      write(1'b0, 32'd3, 32'h0040_2005, 32'h0000_1046, 32'h0000_0042, 12'h000);
      lk_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0004_1ABC, 3'd0});
      lookup(32'h0040_2ABC, 1'b0, o);
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL translate_load got=%h exp=%h", o, e); end
      tick();
      checks++;
      if ({lk_valid, lk_miss, lk_invalid, lk_modified, lk_paddr, lk_cattr} !== '0) begin
         failures++;
         $display("FAIL translate_idle got valid=%b pa=%h exp 0", lk_valid, lk_paddr);
      end
   endtask

   task automatic test_flags();
      lk_t o, e;
      lk_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1010, 3'd0});
      lookup(32'h0040_3010, 1'b1, o);
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL flags_store_modified got=%h exp=%h", o, e); end
      lk_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1010, 3'd0});
      lookup(32'h0040_3010, 1'b0, o);
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL flags_load_clean got=%h exp=%h", o, e); end
      write(1'b0, 32'd4, 32'h0060_0005, 32'h0000_1000, 32'h0000_0000, 12'h000);
      lk_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h0004_0123, 3'd0});
      lookup(32'h0060_0123, 1'b1, o);
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL flags_invalid_over_modified got=%h exp=%h", o, e); end
   endtask

   task automatic test_probe();
      logic [32:0] po, pe;
      pb_q.push_back({1'b1, 32'h8000_0000});
      probe(32'h0040_2006, po);
      pe = pb_q.pop_front();
      checks++;
      if (po !== pe) begin failures++; $display("FAIL probe_asid_miss got=%h exp=%h", po, pe); end
      write(1'b0, 32'd3, 32'h0040_2005, 32'h0000_1047, 32'h0000_0043, 12'h000);
      pb_q.push_back({1'b1, 32'd3});
      probe(32'h0040_2006, po);
      pe = pb_q.pop_front();
      checks++;
      if (po !== pe) begin failures++; $display("FAIL probe_global_hit got=%h exp=%h", po, pe); end
      write(1'b0, 32'd9, 32'h0040_2006, 32'h0000_0000, 32'h0000_0000, 12'h000);
      pb_q.push_back({1'b1, 32'd3});
      probe(32'h0040_2006, po);
      pe = pb_q.pop_front();
      checks++;
      if (po !== pe) begin failures++; $display("FAIL probe_lowest_wins got=%h exp=%h", po, pe); end
   endtask

   task automatic test_tlbwr();
      lk_t o, e;
      cp0_index = 32'd3;
      write(1'b1, 32'd31, 32'h1000_4000, 32'h0000_0007, 32'h0002_801F, 12'h003);
      lk_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h00A0_3FFC, 3'd3});
      lookup(32'h1000_7FFC, 1'b0, o);
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL tlbwr_16k_odd got=%h exp=%h", o, e); end
      lk_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3FFC, 3'd0});
      lookup(32'h1000_3FFC, 1'b1, o);
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL tlbwr_16k_even got=%h exp=%h", o, e); end
   endtask

   task automatic test_read();
      rd_t o, e;
      lk_t lo, le;
      rd_q.push_back('{1'b1, 32'h0040_2005, 32'h0000_1047, 32'h0000_0043, 12'h000});
      read(32'd3, o);
      e = rd_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL read_idx3 got=%h exp=%h", o, e); end
      rd_q.push_back('{1'b1, 32'h1000_0000, 32'h0000_0007, 32'h0002_801F, 12'h003});
      read(32'd31, o);
      e = rd_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL read_idx31_masked got=%h exp=%h", o, e); end
      // tlbwi and tlbwr together: Index (10) wins over Random (11).
      cp0_index    = 32'd10;
      cp0_random   = 32'd11;
      cp0_entryhi  = 32'h0A00_0000;
      cp0_entrylo0 = 32'h0000_0003;
      cp0_entrylo1 = 32'h0000_0002;
      cp0_mask     = 12'h000;
      tlbwi        = 1'b1;
      tlbwr        = 1'b1;
      tick();
      tlbwi = 1'b0;
      tlbwr = 1'b0;
      rd_q.push_back('{1'b1, 32'h0A00_0000, 32'h0000_0002, 32'h0000_0002, 12'h000});
      read(32'd10, o);
      e = rd_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL read_tlbwi_wins got=%h exp=%h", o, e); end
      rd_q.push_back('{1'b1, 32'h0, 32'h0, 32'h0, 12'h000});
      read(32'd11, o);
      e = rd_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL read_not_present got=%h exp=%h", o, e); end
      reset    = 1'b1;
      tlbr_req = 1'b1;
      tlbp_req = 1'b1;
      lk_req   = 1'b1;
      lk_vaddr = 32'h0040_2ABC;
      tick();
      reset    = 1'b0;
      tlbr_req = 1'b0;
      tlbp_req = 1'b0;
      lk_req   = 1'b0;
      checks++;
      if ({tlbr, tlbp, lk_valid} !== 3'b000) begin
         failures++;
         $display("FAIL reset_suppress got tlbr=%b tlbp=%b lk_valid=%b exp 000", tlbr, tlbp, lk_valid);
      end
      lk_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0});
      lookup(32'h0040_2ABC, 1'b0, lo);
      le = lk_q.pop_front();
      checks++;
      if (lo !== le) begin failures++; $display("FAIL post_reset_miss got=%h exp=%h", lo, le); end
   endtask

   task automatic test_back_to_back();
      lk_t o, e;
      cp0_index    = 32'd7;
      cp0_entryhi  = 32'h0080_0000;
      cp0_entrylo0 = 32'h0000_2006;
      cp0_entrylo1 = 32'h0000_0000;
      cp0_mask     = 12'h000;
      tlbwi        = 1'b1;
      lk_req       = 1'b1;
      lk_vaddr     = 32'h0080_0444;
      lk_store     = 1'b0;
      lk_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0});
      tick();
      tlbwi = 1'b0;
      lk_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0008_0444, 3'd0});
      o = cap_lk();
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_same_cycle_miss got=%h exp=%h", o, e); end
      tick();
      lk_req = 1'b0;
      o = cap_lk();
      e = lk_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_next_cycle_hit got=%h exp=%h", o, e); end
   endtask

   initial begin
      reset        = 1'b1;
      tlbwi        = 1'b0;
      tlbwr        = 1'b0;
      tlbr_req     = 1'b0;
      tlbp_req     = 1'b0;
      cp0_index    = '0;
      cp0_random   = '0;
      cp0_entryhi  = '0;
      cp0_entrylo0 = '0;
      cp0_entrylo1 = '0;
      cp0_mask     = '0;
      lk_req       = 1'b0;
      lk_vaddr     = '0;
      lk_store     = 1'b0;
      test_reset();
      test_translate();
      test_flags();
      test_probe();
      test_tlbwr();
      test_read();
      test_back_to_back();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
